// File: rtl/text_writer_pkg.sv
// Shared definitions for the text overlay writer: FSM encoding, bitmap geometry, default origin.
package text_writer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int TEXT_COLS        = 60;
  localparam int TEXT_ROWS        = 10;
  localparam int BEATS_PER_ROW    = 8;
  localparam int DEFAULT_ORIGIN_X = 11;
  localparam int DEFAULT_ORIGIN_Y = 38;

endpackage

// File: rtl/text_writer_fsm.sv
// Load sequencer: tracks IDLE/LOAD/DONE, row/beat position and the write handshake.
module text_writer_fsm
  import text_writer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       vblank,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic       load_done,
  output logic       accept,
  output logic [3:0] row,
  output logic [2:0] beat
);

  state_t state, state_nxt;
  logic   last_beat;

  assign last_beat = (row == 4'(TEXT_ROWS - 1)) && (beat == 3'(BEATS_PER_ROW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // start overrides everything, including a coincident final beat
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD:    if (accept && last_beat) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    wr_ready  = (state == LOAD) && vblank;
    load_done = (state == DONE);
    accept    = wr_valid && wr_ready && !start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= '0;
      beat <= '0;
    end else if (start) begin
      row  <= '0;
      beat <= '0;
    end else if (accept) begin
      beat <= beat + 3'd1;
      if (beat == 3'(BEATS_PER_ROW - 1)) row <= row + 4'd1;
    end
  end

endmodule

// File: rtl/text_writer.sv
// Text overlay: 10x60 tile bitmap loaded in 8-bit beats during vblank, read combinationally per pixel.
module text_writer
  import text_writer_pkg::*;
#(
  parameter int ORIGIN_X = DEFAULT_ORIGIN_X,
  parameter int ORIGIN_Y = DEFAULT_ORIGIN_Y
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       vblank,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       load_done,
  input  logic [9:0] x,
  input  logic [8:0] y,
  output logic       overlay_active
);

  logic                                 accept;
  logic [3:0]                           row;
  logic [2:0]                           beat;
  logic [TEXT_ROWS-1:0][TEXT_COLS-1:0]  bitmap;
  logic [6:0]                           tx;
  logic [5:0]                           ty;
  logic                                 unused_low_bits;

  text_writer_fsm u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .vblank    (vblank),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .load_done (load_done),
    .accept    (accept),
    .row       (row),
    .beat      (beat)
  );

  // Beat 7 spans columns 56..63; only 56..59 exist
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap <= '0;
    end else if (accept) begin
      for (int i = 0; i < 8; i++) begin
        if ({beat, 3'(i)} < 6'(TEXT_COLS)) bitmap[row][{beat, 3'(i)}] <= wr_data[i];
      end
    end
  end

  assign tx = x[9:3] - 7'(ORIGIN_X);
  assign ty = y[8:3] - 6'(ORIGIN_Y);
  assign unused_low_bits = ^{x[2:0], y[2:0]};

  always_comb begin
    overlay_active = 1'b0;
    if (tx < 7'(TEXT_COLS) && ty < 6'(TEXT_ROWS)) overlay_active = bitmap[ty[3:0]][tx[5:0]];
  end

endmodule

// File: doc/text_writer.md
TEXT_WRITER -- requirements
Module: text_writer

Interface
REQ-001 ORIGIN_X (parameter, default 11): left edge of the text window, in 8-pixel tiles.
REQ-002 ORIGIN_Y (parameter, default 38): top edge of the text window, in 8-pixel tiles.
REQ-003 clk  input  1  single system clock; all state is updated on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse; begins (or restarts) a bitmap load.
REQ-006 vblank  input  1  high while the display is outside the visible area; writes are permitted only then.
REQ-007 wr_valid  input  1  wr_data holds a valid beat.
REQ-008 wr_data  input  8  eight bitmap bits; bit i maps to column beat*8+i.
REQ-009 wr_ready  output  1  block accepts a beat this cycle.
REQ-010 load_done  output  1  one-cycle pulse after the final beat is accepted.
REQ-011 x  input  10  current pixel column.
REQ-012 y  input  9  current pixel row.
REQ-013 overlay_active  output  1  current pixel lies on a set bitmap bit.

Function
REQ-014 Storage SHALL be a bitmap of 10 rows x 60 columns, one bit per 8x8-pixel tile.
REQ-015 FSM states SHALL be IDLE, LOAD and DONE; reset state is IDLE.
REQ-016 IDLE->LOAD on start; row counter (4 bit) and beat counter (3 bit) cleared to 0.
REQ-017 start in LOAD or DONE SHALL return to LOAD with both counters 0; already written bits are kept.
REQ-018 wr_ready = (state==LOAD) & vblank; it is 0 in IDLE and DONE.
REQ-019 A beat is accepted on a clock edge where wr_valid & wr_ready; wr_valid without wr_ready is held off with no state change.
REQ-020 Accepted beat SHALL write bits [row][beat*8+i] for i=0..7 where column<60; beat 7 stores bits [3:0] and discards [7:4].
REQ-021 Beat counter SHALL increment per accepted beat, wrap 7->0 and increment row; each row is 8 beats, total 80 beats.
REQ-022 Acceptance of beat (row 9, beat 7) SHALL move LOAD->DONE; DONE SHALL assert load_done for exactly one cycle and then go to IDLE.
REQ-023 If start and an accepted beat coincide, start wins and the beat is dropped.
REQ-024 Read path SHALL be combinational: tx = x[9:3]-ORIGIN_X (7 bit), ty = y[8:3]-ORIGIN_Y (6 bit), both modulo width.
REQ-025 overlay_active = (tx<60) & (ty<10) & bitmap[ty][tx]; outside the window the output is 0 regardless of underflow wrap.
REQ-026 The read path SHALL reflect a written bit from the cycle after acceptance; no shadow buffer.
REQ-027 x[2:0] and y[2:0] SHALL be unused.

Reset
REQ-028 On rst_n low: state IDLE, counters 0, all 600 bitmap bits 0, wr_ready 0, load_done 0, overlay_active 0.
REQ-029 Reset asserted mid-load SHALL abort the load; no partial data remains.

Structure
REQ-030 Shared package SHALL hold the FSM state encoding, TEXT_COLS=60, TEXT_ROWS=10, BEATS_PER_ROW=8 and the default origin tiles.
REQ-031 One sub-module, text_writer_fsm (state, counters, handshake), is natural; the bitmap and read mux stay in text_writer.

Verification
REQ-032 Reset, then x=88,y=304 -> overlay_active=0; wr_ready=0; load_done=0.
REQ-033 start, vblank=1, 80 beats of 8'hFF back-to-back -> wr_ready=1 throughout, load_done pulses one cycle after 80th acceptance; x=88..567, y=304..383 all give 1; x=568 gives 0.
REQ-034 Load with row 0 beat 0 = 8'h01, all else 0 -> x=88,y=304 gives 1; x=96,y=304 gives 0; x=88,y=312 gives 0.
REQ-035 vblank=0 with wr_valid=1 for 20 cycles during LOAD -> wr_ready=0, counters unchanged; after vblank=1 the beats land at row 0 beat 0.
REQ-036 40 beats, then start coincident with beat 41, then 80 beats of 8'h00 -> final bitmap all 0, load_done once.
REQ-037 rst_n low for one cycle after 30 beats of 8'hFF -> state IDLE, x=88,y=304 gives 0.
